// File: rtl/trace_checker.sv
// Commit-trace checker: serialises per-channel committed writes into a FIFO and
// compares them, one per cycle, against an expected-trace stream.
module trace_checker #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ID_W           = 6,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        obs_valid,
  input  logic [NUM_CH*ID_W-1:0]   obs_id,
  input  logic [NUM_CH*DATA_W-1:0] obs_data,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [ID_W-1:0]          exp_id,
  input  logic [DATA_W-1:0]        exp_data,
  input  logic                     exp_last,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [ID_W-1:0]          err_obs_id,
  output logic [DATA_W-1:0]        err_obs_data,
  output logic [ID_W-1:0]          err_exp_id,
  output logic [DATA_W-1:0]        err_exp_data,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned MEM_N = 1 << AW;
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_OVERFLOW = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state, state_n;
  entry_t            mem [MEM_N];
  entry_t            head;
  logic [PW-1:0]     wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [PW-1:0]     used, free, n_push;
  logic [PW-1:0]     ch_off [NUM_CH];
  logic              push_en, overflow, mismatch;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [CNT_W-1:0]  match_cnt_n;
  logic [1:0]        fail_n;
  logic [ID_W-1:0]   err_obs_id_n, err_exp_id_n;
  logic [DATA_W-1:0] err_obs_data_n, err_exp_data_n;
  logic              busy_n, done_n, pass_n;

  // Next-state, FIFO bookkeeping and compare
  always_comb begin
    state_n        = state;
    wr_ptr_n       = wr_ptr;
    rd_ptr_n       = rd_ptr;
    tcnt_n         = tcnt;
    match_cnt_n    = match_cnt;
    fail_n         = fail_code;
    err_obs_id_n   = err_obs_id;
    err_obs_data_n = err_obs_data;
    err_exp_id_n   = err_exp_id;
    err_exp_data_n = err_exp_data;
    push_en        = 1'b0;
    overflow       = 1'b0;
    mismatch       = 1'b0;

    // Each valid channel lands at wr_ptr plus the number of lower valid channels
    n_push = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ch_off[ch] = n_push;
      n_push     = n_push + PW'(obs_valid[ch]);
    end

    used      = wr_ptr - rd_ptr;
    free      = PW'(FIFO_DEPTH) - used;
    head      = mem[rd_ptr[AW-1:0]];
    exp_ready = (state == ST_RUN) && (used != '0) && exp_valid;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n        = ST_RUN;
          wr_ptr_n       = '0;
          rd_ptr_n       = '0;
          tcnt_n         = '0;
          match_cnt_n    = '0;
          fail_n         = FC_NONE;
          err_obs_id_n   = '0;
          err_obs_data_n = '0;
          err_exp_id_n   = '0;
          err_exp_data_n = '0;
        end
      end
      ST_RUN: begin
        overflow = (n_push > free);
        push_en  = !overflow && (n_push != '0);
        if (push_en) wr_ptr_n = wr_ptr + n_push;

        if (exp_ready) begin
          mismatch = (head != {exp_id, exp_data});
          rd_ptr_n = rd_ptr + PW'(1);
          tcnt_n   = '0;
          if (!mismatch && (match_cnt != {CNT_W{1'b1}})) match_cnt_n = match_cnt + CNT_W'(1);
        end else if (TIMEOUT_CYCLES != 0) begin
          tcnt_n = tcnt + TW'(1);
        end

        if (mismatch) begin
          state_n        = ST_DONE;
          fail_n         = FC_MISMATCH;
          err_obs_id_n   = head.id;
          err_obs_data_n = head.data;
          err_exp_id_n   = exp_id;
          err_exp_data_n = exp_data;
        end else if (overflow) begin
          state_n = ST_DONE;
          fail_n  = FC_OVERFLOW;
        end else if (exp_ready && exp_last) begin
          state_n = ST_DONE;
        end else if (!exp_ready && (TIMEOUT_CYCLES != 0) && (tcnt_n == TW'(TIMEOUT_CYCLES))) begin
          state_n = ST_DONE;
          fail_n  = FC_TIMEOUT;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n == ST_RUN);
    done_n = (state_n == ST_DONE);
    pass_n = (state_n == ST_DONE) && (fail_n == FC_NONE);
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tcnt         <= '0;
      match_cnt    <= '0;
      fail_code    <= FC_NONE;
      err_obs_id   <= '0;
      err_obs_data <= '0;
      err_exp_id   <= '0;
      err_exp_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state        <= state_n;
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      tcnt         <= tcnt_n;
      match_cnt    <= match_cnt_n;
      fail_code    <= fail_n;
      err_obs_id   <= err_obs_id_n;
      err_obs_data <= err_obs_data_n;
      err_exp_id   <= err_exp_id_n;
      err_exp_data <= err_exp_data_n;
      busy         <= busy_n;
      done         <= done_n;
      pass         <= pass_n;
    end
  end

  // Event storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (obs_valid[ch]) begin
          mem[AW'(wr_ptr + ch_off[ch])] <= {obs_id[ch*ID_W +: ID_W], obs_data[ch*DATA_W +: DATA_W]};
        end
      end
    end
  end

endmodule
